// File: rtl/k16_mem_arbiter_pkg.sv
// Shared state encoding and width helper for the K16 memory arbiter.
package k16_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } k16_state_e;

  // ceil(log2(n)) with a floor of 1 so single-port / zero-wait builds still get a real bit
  function automatic int k16_clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/k16_rr_picker.sv
// Combinational round-robin picker: first requesting port after 'last', wrapping.
module k16_rr_picker
  import k16_mem_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  localparam int GW = k16_clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [GW-1:0]        last,
  output logic                 valid,
  output logic [GW-1:0]        idx
);

  // Smallest rotational distance from last+1 wins; distance 0 is the port right after last.
  always_comb begin : pick
    int best;
    int d;
    valid = 1'b0;
    idx   = '0;
    best  = NUM_PORTS;
    d     = 0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      d = (j + NUM_PORTS - int'(last) - 1) % NUM_PORTS;
      if (req[j] && d < best) begin
        best  = d;
        valid = 1'b1;
        idx   = GW'(j);
      end
    end
  end

endmodule

// File: rtl/k16_mem_arbiter.sv
// Round-robin arbiter sharing one registered-read single-port RAM among bus masters.
module k16_mem_arbiter
  import k16_mem_arbiter_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int NUM_PORTS   = 2,
  parameter int WAIT_STATES = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        we,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata,
  output logic [DATA_W-1:0]           rdata,
  output logic [NUM_PORTS-1:0]        ack,
  output logic [NUM_PORTS-1:0]        hold,
  output logic                        busy,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic                        mem_we,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int GW = k16_clog2(NUM_PORTS);
  localparam int CW = k16_clog2(WAIT_STATES + 1);

  k16_state_e        state, state_nx;
  logic [GW-1:0]     grant, last_grant;
  logic [CW-1:0]     cnt;
  logic              txn_we;      // mem_we drops after one cycle, so keep the direction here
  logic [DATA_W-1:0] rdata_r;
  logic              pick_vld;
  logic [GW-1:0]     pick_idx;

  logic [ADDR_W-1:0] addr_a  [NUM_PORTS];
  logic [DATA_W-1:0] wdata_a [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
    assign addr_a[p]  = addr[p*ADDR_W +: ADDR_W];
    assign wdata_a[p] = wdata[p*DATA_W +: DATA_W];
  end

  k16_rr_picker #(.NUM_PORTS(NUM_PORTS)) u_pick (
    .req   (req),
    .last  (last_grant),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next-state: IDLE -> ACCESS (1+WAIT_STATES cycles) -> RESP (1 cycle) -> IDLE
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:   if (pick_vld)   state_nx = ST_ACCESS;
      ST_ACCESS: if (cnt == '0)  state_nx = ST_RESP;
      ST_RESP:                   state_nx = ST_IDLE;
      default:                   state_nx = ST_IDLE;
    endcase
  end

  // Grant capture, RAM control registers, wait counter and read-data hold register
  always_ff @(posedge clk) begin
    if (reset) begin
      grant      <= '0;
      last_grant <= GW'(NUM_PORTS - 1);
      cnt        <= '0;
      txn_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      rdata_r    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (pick_vld) begin
          grant     <= pick_idx;
          txn_we    <= we[pick_idx];
          mem_we    <= we[pick_idx];
          mem_addr  <= addr_a[pick_idx];
          mem_wdata <= wdata_a[pick_idx];
          cnt       <= CW'(WAIT_STATES);
        end
        ST_ACCESS: begin
          mem_we <= 1'b0;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        ST_RESP: begin
          last_grant <= grant;
          if (!txn_we) rdata_r <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // Ack pulse and read data: RAM data passes straight through in the read's RESP cycle
  always_comb begin
    ack   = '0;
    rdata = rdata_r;
    if (state == ST_RESP) begin
      ack[grant] = 1'b1;
      if (!txn_we) rdata = mem_rdata;
    end
  end

  assign hold = req & ~ack;
  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_k16_mem_arbiter.sv
// Randomized bench: two arbiter configs, each checked every cycle against a transaction-timing model.
module tb_k16_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] init_val(input int i);
    case (i)
      0:       return 16'h6257;
      1:       return 16'h0480;
      2:       return 16'h9FFF;
      default: return 16'(i * 257) ^ 16'h5A5A;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int NP     = (g == 0) ? 2 : 4;
    localparam int WS     = (g == 0) ? 0 : 3;
    localparam int NCYC   = 3000;
    localparam int SAT    = 100;
    localparam int RST_AT = 1500;

    logic              rst;
    logic [NP-1:0]     req, we, ack, hold;
    logic [NP*16-1:0]  addr, wdata;
    logic [15:0]       rdata, mem_addr, mem_wdata, mem_rdata;
    logic              mem_we, busy;
    logic [15:0]       ram [256];
    bit                ram_ok   = 1'b0;
    bit                fin_flag = 1'b0;

    k16_mem_arbiter #(.DATA_W(16), .ADDR_W(16), .NUM_PORTS(NP), .WAIT_STATES(WS)) dut (
      .clk(clk), .reset(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata), .ack(ack), .hold(hold), .busy(busy),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    // Synchronous RAM, 1-cycle registered read, preloaded on the first edge
    always @(posedge clk) begin
      if (!ram_ok) begin
        for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
        ram_ok <= 1'b1;
      end else begin
        if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= ram[mem_addr[7:0]];
      end
    end

    initial begin : stim
      logic [15:0] ref_mem [256];
      bit          m_busy, m_we, rst_now, rst_done, post_rst;
      int          m_g, m_last, t_start, best;
      logic [15:0] m_addr, m_wd, m_rd, m_maddr, m_mwd, rd_exp;
      logic [NP-1:0] fin, pend, drop, ack_exp;
      int          log_q[$];

      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
      m_busy = 0; m_we = 0; m_g = 0; m_last = NP - 1; t_start = 0;
      m_addr = 0; m_wd = 0; m_rd = 0; m_maddr = 0; m_mwd = 0;
      fin = '0; pend = '0; drop = '0;
      rst_done = 0; post_rst = 0;
      rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;

      for (int c = 0; c < NCYC; c++) begin
        @(negedge clk);
        // reset: two cycles at start, then once during the first ACCESS cycle of a write
        rst_now = (c < 2);
        if (!rst_done && c >= RST_AT && m_busy && m_we && c == t_start + 1) begin
          rst_now = 1; rst_done = 1;
        end
        // masters: keep request stable until ack, then maybe issue another
        for (int p = 0; p < NP; p++) begin
          if (fin[p]) begin pend[p] = 0; drop[p] = 0; end
          if (rst_now && c >= 2 && drop[p]) begin pend[p] = 0; drop[p] = 0; end
          if (!pend[p] && c >= 2 && (c < SAT || rst_now || $urandom_range(0, 2) == 0)) begin
            pend[p] = 1; drop[p] = 0;
            we[p] = (c == 2 || rst_now) ? 1'b0 : 1'($urandom_range(0, 1));
            addr[p*16 +: 16]  = (c == 2) ? 16'(p) : 16'($urandom_range(0, 15));
            wdata[p*16 +: 16] = 16'($urandom);
          end else if (pend[p] && c >= SAT && m_busy && m_g == p && c > t_start
                       && $urandom_range(0, 15) == 0) begin
            drop[p] = 1;   // abandon mid-transaction; ack must still arrive
          end
        end
        req = pend & ~drop;
        rst = rst_now;
        #1;

        // expected outputs for this cycle from the transaction timeline
        ack_exp = '0;
        if (m_busy && c == t_start + 2 + WS) ack_exp[m_g] = 1'b1;
        rd_exp = (ack_exp != '0 && !m_we) ? ref_mem[m_addr[7:0]] : m_rd;
        if (c >= 1) begin
          chk($sformatf("cfg%0d ack c%0d", g, c),    64'(ack),       64'(ack_exp));
          chk($sformatf("cfg%0d hold c%0d", g, c),   64'(hold),      64'(req & ~ack_exp));
          chk($sformatf("cfg%0d busy c%0d", g, c),   64'(busy),      64'(m_busy));
          chk($sformatf("cfg%0d mem_we c%0d", g, c), 64'(mem_we),    64'(m_busy && m_we && c == t_start + 1));
          chk($sformatf("cfg%0d maddr c%0d", g, c),  64'(mem_addr),  64'(m_maddr));
          chk($sformatf("cfg%0d mwdata c%0d", g, c), 64'(mem_wdata), 64'(m_mwd));
          chk($sformatf("cfg%0d rdata c%0d", g, c),  64'(rdata),     64'(rd_exp));
        end
        fin = ack_exp;
        for (int p = 0; p < NP; p++) if (ack[p] === 1'b1) begin
          if (c < SAT && log_q.size() < 12) log_q.push_back(p);
          if (post_rst) begin
            chk($sformatf("cfg%0d first_after_reset", g), 64'(p), 64'(0));
            post_rst = 0;
          end
        end

        // advance the model across the coming edge
        if (m_busy && m_we && c == t_start + 1) ref_mem[m_addr[7:0]] = m_wd;
        if (m_busy && c == t_start + 2 + WS) begin
          if (!m_we) m_rd = ref_mem[m_addr[7:0]];
          m_last = m_g;
          m_busy = 0;
        end else if (!m_busy && req != '0) begin
          best = NP;
          for (int k = 1; k <= NP; k++)
            if (best == NP && req[(m_last + k) % NP]) best = (m_last + k) % NP;
          m_g = best; m_we = we[best];
          m_addr = addr[best*16 +: 16]; m_wd = wdata[best*16 +: 16];
          m_maddr = m_addr; m_mwd = m_wd;
          t_start = c; m_busy = 1;
        end
        if (rst_now) begin
          m_busy = 0; m_last = NP - 1; m_rd = 0; m_maddr = 0; m_mwd = 0;
          if (c >= 2) post_rst = 1;
        end
      end

      // saturated start: strict rotation 0,1,..,NP-1,0,...
      chk($sformatf("cfg%0d rr_count", g), 64'(log_q.size()), 64'(12));
      foreach (log_q[k]) chk($sformatf("cfg%0d rr_order%0d", g, k), 64'(log_q[k]), 64'(k % NP));
      fin_flag = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(cfg[0].fin_flag && cfg[1].fin_flag) && t < 10000) begin
      @(posedge clk);
      t++;
    end
    if (!(cfg[0].fin_flag && cfg[1].fin_flag))
      chk("timeout", 64'({cfg[1].fin_flag, cfg[0].fin_flag}), 64'(3));
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
